// File: rtl/cplx_alu_seq.sv
// Sequential complex-number ALU. Operands are packed {RE, IM}, with each
// component a signed W-bit value. All multiply opcodes share one WxW
// multiplier: it produces one product per MUL cycle, and the products are
// accumulated at 2W+1 bits. Every result is narrowed to W bits per component,
// either saturated or wrapped, and is held until the next done.
module cplx_alu_seq #(
  parameter int W    = 32,
  parameter int FRAC = 0,
  parameter int SAT  = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [3:0]     opr,
  input  logic [2*W-1:0] inA,
  input  logic [2*W-1:0] inB,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] outAB,
  output logic           ovf,
  output logic           err
);

  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_CMUL = 4'b0100;
  localparam logic [3:0] OP_PMUL = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_CONJ = 4'b1011;
  localparam logic [3:0] OP_MAG  = 4'b1100;

  // Representable range of one W-bit component, held at accumulator width.
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

  state_t state, state_nxt;
  logic [3:0] op_q;
  logic signed [W-1:0] ar, ai, br, bi;
  logic [1:0] cnt, last_cnt;
  logic signed [2*W:0] acc_re, acc_im;
  logic signed [W-1:0] mx, my;
  logic signed [2*W-1:0] mxe, mye, prod;
  logic signed [2*W:0] prod_x;
  logic to_im, neg_p, accept;
  logic signed [W:0] s_re, s_im, d_re, d_im, n_im;
  logic signed [2*W:0] res_re, res_im;
  logic res_err;
  logic [W:0] nr_re, nr_im;

  function automatic logic signed [2*W:0] sx_w(input logic signed [W-1:0] v);
    return {{(W+1){v[W-1]}}, v};
  endfunction

  function automatic logic signed [2*W:0] sx_w1(input logic signed [W:0] v);
    return {{W{v[W]}}, v};
  endfunction

  // Returns {out_of_range, narrowed component}.
  function automatic logic [W:0] narrow(input logic signed [2*W:0] v);
    logic o;
    logic [W-1:0] r;
    o = (v > MAXV) || (v < MINV);
    if (o && (SAT != 0)) r = v[2*W] ? MINV[W-1:0] : MAXV[W-1:0];
    else                 r = v[W-1:0];
    return {o, r};
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_CMUL) || (op == OP_PMUL) || (op == OP_MAG);
  endfunction

  assign busy     = (state != IDLE);
  assign accept   = start && (state == IDLE);
  assign last_cnt = (op_q == OP_CMUL) ? 2'd3 : 2'd1;

  // Next-state logic. Multiply opcodes step through MUL once per product.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = is_mul(opr) ? MUL : FIN;
      MUL:     if (cnt == last_cnt) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Multiplier operand select and product routing.
  // Product order is ArBr, AiBi, ArBi, AiBr, so mx alternates Ar/Ai.
  // |A|^2 squares the same operand on both multiplier inputs.
  always_comb begin
    mx = cnt[0] ? ai : ar;
    case (cnt)
      2'd0:    my = br;
      2'd1:    my = bi;
      2'd2:    my = bi;
      default: my = br;
    endcase
    if (op_q == OP_MAG) my = mx;
    mxe    = {{W{mx[W-1]}}, mx};
    mye    = {{W{my[W-1]}}, my};
    prod   = (mxe * mye) >>> FRAC;
    prod_x = {prod[2*W-1], prod};
    to_im  = cnt[1] || ((op_q == OP_PMUL) && cnt[0]);
    neg_p  = (op_q == OP_CMUL) && (cnt == 2'd1);
  end

  // Result formation at wide precision, before narrowing.
  always_comb begin
    s_re    = {ar[W-1], ar} + {br[W-1], br};
    s_im    = {ai[W-1], ai} + {bi[W-1], bi};
    d_re    = {ar[W-1], ar} - {br[W-1], br};
    d_im    = {ai[W-1], ai} - {bi[W-1], bi};
    n_im    = {(W+1){1'b0}} - {ai[W-1], ai};
    res_re  = '0;
    res_im  = '0;
    res_err = 1'b0;
    case (op_q)
      OP_A:    begin res_re = sx_w(ar);    res_im = sx_w(ai);    end
      OP_B:    begin res_re = sx_w(br);    res_im = sx_w(bi);    end
      OP_ADD:  begin res_re = sx_w1(s_re); res_im = sx_w1(s_im); end
      OP_SUB:  begin res_re = sx_w1(d_re); res_im = sx_w1(d_im); end
      OP_CMUL, OP_PMUL, OP_MAG:
               begin res_re = acc_re;      res_im = acc_im;      end
      OP_EQ:   res_im = {{(2*W){1'b0}}, ((ar == br) && (ai == bi))};
      OP_CONJ: begin res_re = sx_w(ar);    res_im = sx_w1(n_im); end
      default: res_err = 1'b1;
    endcase
    nr_re = narrow(res_re);
    nr_im = narrow(res_im);
  end

  // Operand capture, product accumulation and the registered result/flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      ar     <= '0;
      ai     <= '0;
      br     <= '0;
      bi     <= '0;
      cnt    <= '0;
      acc_re <= '0;
      acc_im <= '0;
      outAB  <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= opr;
        ar     <= inA[2*W-1:W];
        ai     <= inA[W-1:0];
        br     <= inB[2*W-1:W];
        bi     <= inB[W-1:0];
        cnt    <= '0;
        acc_re <= '0;
        acc_im <= '0;
      end else if (state == MUL) begin
        cnt <= cnt + 2'd1;
        if (to_im)      acc_im <= acc_im + prod_x;
        else if (neg_p) acc_re <= acc_re - prod_x;
        else            acc_re <= acc_re + prod_x;
      end
      if (state == FIN) begin
        outAB <= {nr_re[W-1:0], nr_im[W-1:0]};
        ovf   <= nr_re[W] | nr_im[W];
        err   <= res_err;
      end
      done <= (state == FIN);
    end
  end

endmodule

// File: tb/tb_cplx_alu_seq.sv
// Bench for cplx_alu_seq. Three instances share the same inputs: one
// saturating, one wrapping, and one with 16 fractional bits. Directed
// scenarios are followed by random operations, all checked against an
// arithmetic reference model.
module tb_cplx_alu_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  opr   = 4'd0;
  logic [63:0] inA   = 64'd0;
  logic [63:0] inB   = 64'd0;

  logic busy0, done0, ovf0, err0; logic [63:0] out0;
  logic busy1, done1, ovf1, err1; logic [63:0] out1;
  logic busy2, done2, ovf2, err2; logic [63:0] out2;

  int checks = 0;
  int failures = 0;

  cplx_alu_seq #(.W(32), .FRAC(0), .SAT(1)) u_sat (
    .clock(clock), .reset(reset), .start(start), .opr(opr), .inA(inA), .inB(inB),
    .busy(busy0), .done(done0), .outAB(out0), .ovf(ovf0), .err(err0));
  cplx_alu_seq #(.W(32), .FRAC(0), .SAT(0)) u_wrap (
    .clock(clock), .reset(reset), .start(start), .opr(opr), .inA(inA), .inB(inB),
    .busy(busy1), .done(done1), .outAB(out1), .ovf(ovf1), .err(err1));
  cplx_alu_seq #(.W(32), .FRAC(16), .SAT(1)) u_frac (
    .clock(clock), .reset(reset), .start(start), .opr(opr), .inA(inA), .inB(inB),
    .busy(busy2), .done(done2), .outAB(out2), .ovf(ovf2), .err(err2));

  always #5 clock = ~clock;

  // Reference model: exact complex arithmetic, then per-component narrowing.
  // Returns {err, ovf, RE[31:0], IM[31:0]}.
  function automatic logic [65:0] model(input logic [3:0] op, input logic [63:0] a,
                                        input logic [63:0] b, input int sat, input int frac);
    logic signed [127:0] ar, ai, br, bi, re, im;
    logic er, ovr, ovi;
    logic [31:0] ro, io;
    ar = $signed(a[63:32]); ai = $signed(a[31:0]);
    br = $signed(b[63:32]); bi = $signed(b[31:0]);
    re = 0; im = 0; er = 1'b0;
    case (op)
      4'h0: begin re = ar; im = ai; end
      4'h1: begin re = br; im = bi; end
      4'h2: begin re = ar + br; im = ai + bi; end
      4'h3: begin re = ar - br; im = ai - bi; end
      4'h4: begin
        re = ((ar * br) >>> frac) - ((ai * bi) >>> frac);
        im = ((ar * bi) >>> frac) + ((ai * br) >>> frac);
      end
      4'h6: begin re = (ar * br) >>> frac; im = (ai * bi) >>> frac; end
      4'h8: im = ((ar == br) && (ai == bi)) ? 128'sd1 : 128'sd0;
      4'hB: begin re = ar; im = -ai; end
      4'hC: re = ((ar * ar) >>> frac) + ((ai * ai) >>> frac);
      default: er = 1'b1;
    endcase
    ovr = (re > 128'sd2147483647) || (re < -128'sd2147483648);
    ovi = (im > 128'sd2147483647) || (im < -128'sd2147483648);
    ro = (ovr && sat != 0) ? ((re < 0) ? 32'h80000000 : 32'h7FFFFFFF) : re[31:0];
    io = (ovi && sat != 0) ? ((im < 0) ? 32'h80000000 : 32'h7FFFFFFF) : im[31:0];
    return {er, ovr | ovi, ro, io};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == 4'h4) return 5;
    if (op == 4'h6 || op == 4'hC) return 3;
    return 1;
  endfunction

  function automatic logic [31:0] rcomp();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return $urandom_range(0, 16) - 32'd8;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from an idle point #1 after an edge. Report the
  // number of edges from accept to done, and whether busy stayed high until
  // done and dropped in the done cycle.
  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output bit busy_ok);
    opr = op; inA = a; inB = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      lat++;
      if (done0) begin
        if (busy0) busy_ok = 1'b0;
        break;
      end
      if (!busy0) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy0, done0, ovf0, err0, out0} !== 68'd0) begin
      failures++; $display("FAIL reset_sat got=%h exp=0", {busy0, done0, ovf0, err0, out0});
    end
    checks++;
    if ({busy1, done1, ovf1, err1, out1, busy2, done2, ovf2, err2, out2} !== 136'd0) begin
      failures++; $display("FAIL reset_others got=%h exp=0", {busy1, done1, ovf1, err1, out1, busy2, done2, ovf2, err2, out2});
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_cmul();
    int lat; bit bok;
    do_op(4'h4, {32'd3, 32'd4}, {32'd1, 32'hFFFFFFFE}, lat, bok);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL cmul_latency got=%0d exp=5", lat); end
    checks++;
    if (!bok) begin failures++; $display("FAIL cmul_busy got=0 exp=1"); end
    checks++;
    if ({err0, ovf0, out0} !== {2'b00, 32'd11, 32'hFFFFFFFE}) begin
      failures++; $display("FAIL cmul_result got=%h exp=%h", {err0, ovf0, out0}, {2'b00, 32'd11, 32'hFFFFFFFE});
    end
    @(posedge clock); #1;
    checks++;
    if (done0 !== 1'b0) begin failures++; $display("FAIL cmul_done_pulse got=%b exp=0", done0); end
  endtask

  task automatic test_add_sat();
    int lat; bit bok;
    do_op(4'h2, {32'h7FFFFFFF, 32'd0}, {32'd1, 32'd0}, lat, bok);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_latency got=%0d exp=1", lat); end
    checks++;
    if ({err0, ovf0, out0} !== {2'b01, 32'h7FFFFFFF, 32'd0}) begin
      failures++; $display("FAIL add_sat got=%h exp=%h", {err0, ovf0, out0}, {2'b01, 32'h7FFFFFFF, 32'd0});
    end
    checks++;
    if ({err1, ovf1, out1} !== {2'b01, 32'h80000000, 32'd0}) begin
      failures++; $display("FAIL add_wrap got=%h exp=%h", {err1, ovf1, out1}, {2'b01, 32'h80000000, 32'd0});
    end
  endtask

  task automatic test_eq_illegal();
    int lat; bit bok;
    do_op(4'h8, {32'd5, 32'hFFFFFFF9}, {32'd5, 32'hFFFFFFF9}, lat, bok);
    checks++;
    if ({err0, ovf0, out0} !== {2'b00, 64'd1}) begin
      failures++; $display("FAIL eq_true got=%h exp=%h", {err0, ovf0, out0}, {2'b00, 64'd1});
    end
    do_op(4'h8, {32'd5, 32'hFFFFFFF9}, {32'd5, 32'hFFFFFFF8}, lat, bok);
    checks++;
    if ({err0, ovf0, out0} !== {2'b00, 64'd0}) begin
      failures++; $display("FAIL eq_false got=%h exp=%h", {err0, ovf0, out0}, {2'b00, 64'd0});
    end
    do_op(4'h5, {32'd5, 32'hFFFFFFF9}, {32'd5, 32'hFFFFFFF9}, lat, bok);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++;
    if ({err0, ovf0, out0} !== {2'b10, 64'd0}) begin
      failures++; $display("FAIL illegal got=%h exp=%h", {err0, ovf0, out0}, {2'b10, 64'd0});
    end
  endtask

  task automatic test_conj();
    int lat; bit bok;
    do_op(4'hB, {32'd5, 32'h80000000}, 64'd0, lat, bok);
    checks++;
    if ({err0, ovf0, out0} !== {2'b01, 32'd5, 32'h7FFFFFFF}) begin
      failures++; $display("FAIL conj_min_sat got=%h exp=%h", {err0, ovf0, out0}, {2'b01, 32'd5, 32'h7FFFFFFF});
    end
    checks++;
    if ({err1, ovf1, out1} !== {2'b01, 32'd5, 32'h80000000}) begin
      failures++; $display("FAIL conj_min_wrap got=%h exp=%h", {err1, ovf1, out1}, {2'b01, 32'd5, 32'h80000000});
    end
    do_op(4'hB, {32'd5, 32'd7}, 64'd0, lat, bok);
    checks++;
    if ({err0, ovf0, out0} !== {2'b00, 32'd5, 32'hFFFFFFF9}) begin
      failures++; $display("FAIL conj got=%h exp=%h", {err0, ovf0, out0}, {2'b00, 32'd5, 32'hFFFFFFF9});
    end
  endtask

  task automatic test_frac();
    int lat; bit bok;
    do_op(4'h6, {32'h00018000, 32'd0}, {32'h00020000, 32'd0}, lat, bok);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL frac_latency got=%0d exp=3", lat); end
    checks++;
    if ({err2, ovf2, out2} !== {2'b00, 32'h00030000, 32'd0}) begin
      failures++; $display("FAIL frac_pmul got=%h exp=%h", {err2, ovf2, out2}, {2'b00, 32'h00030000, 32'd0});
    end
  endtask

  // A start while busy is ignored. A start in the done cycle is accepted.
  task automatic test_back_to_back();
    int n, lat, dcnt; bit bok;
    opr = 4'h4; inA = {32'd3, 32'd4}; inB = {32'd1, 32'hFFFFFFFE}; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      n++;
      if (n == 2) begin start = 1'b1; opr = 4'h0; inA = {32'd99, 32'd98}; inB = 64'd0; end
      if (n == 3) start = 1'b0;
      if (done0) break;
    end
    checks++;
    if (n !== 5) begin failures++; $display("FAIL reject_latency got=%0d exp=5", n); end
    checks++;
    if ({err0, ovf0, out0} !== {2'b00, 32'd11, 32'hFFFFFFFE}) begin
      failures++; $display("FAIL reject_result got=%h exp=%h", {err0, ovf0, out0}, {2'b00, 32'd11, 32'hFFFFFFFE});
    end
    do_op(4'h3, {32'd10, 32'd20}, {32'd3, 32'd30}, lat, bok);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL b2b_latency got=%0d exp=1", lat); end
    checks++;
    if ({err0, ovf0, out0} !== {2'b00, 32'd7, 32'hFFFFFFF6}) begin
      failures++; $display("FAIL b2b_result got=%h exp=%h", {err0, ovf0, out0}, {2'b00, 32'd7, 32'hFFFFFFF6});
    end
    dcnt = 0;
    repeat (6) begin @(posedge clock); #1; if (done0) dcnt++; end
    checks++;
    if (dcnt !== 0) begin failures++; $display("FAIL reject_extra_done got=%0d exp=0", dcnt); end
  endtask

  task automatic test_reset_mid();
    int lat, dcnt; bit bok; logic [63:0] a, b; logic [65:0] e;
    opr = 4'h4; inA = {32'd3, 32'd4}; inB = {32'd1, 32'hFFFFFFFE}; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy0, done0, ovf0, err0, out0} !== 68'd0) begin
      failures++; $display("FAIL reset_mid_out got=%h exp=0", {busy0, done0, ovf0, err0, out0});
    end
    @(posedge clock); #1;
    reset = 1'b1;
    dcnt = 0;
    repeat (8) begin @(posedge clock); #1; if (done0 || done1 || done2) dcnt++; end
    checks++;
    if (dcnt !== 0) begin failures++; $display("FAIL reset_mid_done got=%0d exp=0", dcnt); end
    a = {rcomp(), rcomp()}; b = {rcomp(), rcomp()};
    e = model(4'h4, a, b, 1, 0);
    do_op(4'h4, a, b, lat, bok);
    checks++;
    if (lat !== 5 || {err0, ovf0, out0} !== e) begin
      failures++; $display("FAIL reset_mid_next got=%0d/%h exp=5/%h", lat, {err0, ovf0, out0}, e);
    end
  endtask

  task automatic test_random();
    int lat, gap; bit bok; logic [3:0] op; logic [63:0] a, b;
    logic [65:0] e0, e1, e2;
    for (int t = 0; t < 150; t++) begin
      op = 4'($urandom_range(0, 15));
      a = {rcomp(), rcomp()};
      b = ($urandom_range(0, 3) == 0) ? a : {rcomp(), rcomp()};
      e0 = model(op, a, b, 1, 0);
      e1 = model(op, a, b, 0, 0);
      e2 = model(op, a, b, 1, 16);
      do_op(op, a, b, lat, bok);
      checks++;
      if (lat !== lat_of(op) || !bok) begin
        failures++; $display("FAIL rnd_timing op=%h got=%0d busy_ok=%b exp=%0d", op, lat, bok, lat_of(op));
      end
      checks++;
      if ({err0, ovf0, out0} !== e0) begin
        failures++; $display("FAIL rnd_sat op=%h a=%h b=%h got=%h exp=%h", op, a, b, {err0, ovf0, out0}, e0);
      end
      checks++;
      if ({err1, ovf1, out1} !== e1) begin
        failures++; $display("FAIL rnd_wrap op=%h a=%h b=%h got=%h exp=%h", op, a, b, {err1, ovf1, out1}, e1);
      end
      checks++;
      if ({err2, ovf2, out2} !== e2) begin
        failures++; $display("FAIL rnd_frac op=%h a=%h b=%h got=%h exp=%h", op, a, b, {err2, ovf2, out2}, e2);
      end
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        inA = $urandom; inB = $urandom; opr = 4'($urandom);
        repeat (gap) @(posedge clock);
        #1;
        checks++;
        if ({done0, err0, ovf0, out0} !== {1'b0, e0}) begin
          failures++; $display("FAIL rnd_hold got=%h exp=%h", {done0, err0, ovf0, out0}, {1'b0, e0});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cmul();
    test_add_sat();
    test_eq_illegal();
    test_conj();
    test_frac();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
